// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding a shared 2:1 data mux.
// Granted bursts pass through a one-entry registered output stage.
module mux_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_last,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_last,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_END = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_A = 2'd1;
  localparam logic [1:0] S_GNT_B = 2'd2;

  logic [1:0]            r_state;
  logic                  r_last_b;
  logic [CW-1:0]         r_beat_cnt;
  logic                  r_sel;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;

  logic                  w_slot_free;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_acc;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic                  w_beat_last;
  logic                  w_end;
  logic                  w_pick_a;
  logic                  w_pick_b;

  assign w_slot_free = !r_out_valid | out_ready;
  assign w_gnt_a     = (r_state == S_GNT_A);
  assign w_gnt_b     = (r_state == S_GNT_B);

  assign a_ready = w_gnt_a & w_slot_free;
  assign b_ready = w_gnt_b & w_slot_free;

  assign w_acc       = (a_valid & a_ready) | (b_valid & b_ready);
  assign w_beat_data = w_gnt_b ? b_data : a_data;
  assign w_beat_last = w_gnt_b ? b_last : a_last;

  // Burst ends on the requester's last flag or when the cap is hit.
  assign w_end = w_beat_last | (r_beat_cnt == CNT_END);

  // r_last_b=1 means B was served last, so A wins a tie.
  assign w_pick_a = a_valid & (!b_valid | r_last_b);
  assign w_pick_b = b_valid & !w_pick_a;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sel       = r_sel;
  assign busy      = (r_state != S_IDLE);

  // Grant FSM: pick a requester in IDLE, hold it until its burst ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_b   <= 1'b1;
      r_beat_cnt <= '0;
      r_sel      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_a) begin
            r_state <= S_GNT_A;
            r_sel   <= 1'b0;
          end else if (w_pick_b) begin
            r_state <= S_GNT_B;
            r_sel   <= 1'b1;
          end
        end
        S_GNT_A, S_GNT_B: begin
          if (w_acc) begin
            if (w_end) begin
              r_state    <= S_IDLE;
              r_last_b   <= w_gnt_b;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // Output slot: load on accept, drain when the sink takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat_data;
      r_out_last  <= w_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
